// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator.
//   MODE_EDGE / MODE_CENTER : counter alignment encoding (center_mode input)
//   DEF_*                   : default parameter values
//   duty_of()               : extracts one channel's duty from the flattened bus
// Optional feature macro used elsewhere in this slice: PWM_POLARITY_EN.
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_CNT_W   = 12;
  localparam int DEF_PRESC_W = 8;

  // Widest flattened duty bus the helper accepts (NUM_CH*CNT_W).
  localparam int DUTY_BUS_MAX = 1024;

  // Channel ch of a bus made of w-bit fields; ch = 0 sits in the LSBs.
  function automatic logic [31:0] duty_of(input logic [DUTY_BUS_MAX-1:0] bus,
                                          input int ch, input int w);
    logic [DUTY_BUS_MAX-1:0] sh;
    logic [31:0]             mask;
    sh   = bus >> (ch * w);
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return sh[31:0] & mask;
  endfunction

endpackage

// File: rtl/pwm_multi_channel_if.sv
// Configuration bus of the PWM generator (register block side = master).
//   period, center_mode, duty[, polarity] : shadow values, sampled on a load
//   load_req  : one-cycle request to copy the shadow values into the active set
//   load_done : one-cycle pulse the clk after the active set was updated
// Handshake: load_req is a fire-and-forget pulse (no back-pressure); a request
// stays pending inside the PWM until the next period boundary (or at once while
// disabled), and exactly one load_done answers it. Requests arriving while one
// is pending merge into it. The shadow values must be stable until load_done.
// Macro PWM_POLARITY_EN adds the per-channel polarity field.
interface pwm_multi_channel_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 12
);
  logic [CNT_W-1:0]        period;
  logic                    center_mode;
  logic [NUM_CH*CNT_W-1:0] duty;
`ifdef PWM_POLARITY_EN
  logic [NUM_CH-1:0]       polarity;
`endif
  logic                    load_req;
  logic                    load_done;

`ifdef PWM_POLARITY_EN
  modport master (output period, center_mode, duty, polarity, load_req,
                  input  load_done);
  modport slave  (input  period, center_mode, duty, polarity, load_req,
                  output load_done);
`else
  modport master (output period, center_mode, duty, load_req,
                  input  load_done);
  modport slave  (input  period, center_mode, duty, load_req,
                  output load_done);
`endif
endinterface

// File: rtl/pwm_multi_channel_timebase.sv
// Prescaler plus up/down period counter shared by all PWM channels.
//   enable     : low holds prescaler, counter and direction at 0
//   prescale   : counter advances once every prescale+1 clk
//   period_act / mode_act : active (already shadow-loaded) period and mode
//   cnt_value  : current counter value
//   tick       : this clk advances the counter
//   boundary   : the counter sits at its period end, i.e. the next tick wraps
//                it to 0; tick & boundary marks the boundary tick
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [CNT_W-1:0]   period_act,
  input  logic               mode_act,
  output logic [CNT_W-1:0]   cnt_value,
  output logic               tick,
  output logic               boundary
);

  logic [PRESC_W-1:0] presc_cnt;
  logic               dir_down;
  logic [CNT_W-1:0]   cnt_next;
  logic               dir_next;

  assign tick = enable && (presc_cnt == prescale);

  // Next count for the coming tick. Every wrap lands on 0 counting up, which
  // is also where a shadow load restarts the count, so no restart path exists.
  always_comb begin
    cnt_next = cnt_value;
    dir_next = dir_down;
    boundary = 1'b0;
    if (period_act == '0) begin
      cnt_next = '0;
      dir_next = 1'b0;
      boundary = 1'b1;
    end else if (mode_act == MODE_EDGE) begin
      dir_next = 1'b0;
      if (cnt_value >= period_act) begin
        cnt_next = '0;
        boundary = 1'b1;
      end else begin
        cnt_next = cnt_value + 1'b1;
      end
    end else if (dir_down || cnt_value >= period_act) begin
      // Falling half; the top turnaround is folded in here so period=1
      // goes 0,1,0 with the boundary on the step back to 0.
      if (cnt_value <= CNT_W'(1)) begin
        cnt_next = '0;
        dir_next = 1'b0;
        boundary = 1'b1;
      end else begin
        cnt_next = cnt_value - 1'b1;
        dir_next = 1'b1;
      end
    end else begin
      cnt_next = cnt_value + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
      cnt_value <= '0;
      dir_down  <= 1'b0;
    end else if (!enable) begin
      presc_cnt <= '0;
      cnt_value <= '0;
      dir_down  <= 1'b0;
    end else begin
      // >= so a prescale lowered below the running count wraps at once.
      if (presc_cnt >= prescale) presc_cnt <= '0;
      else                       presc_cnt <= presc_cnt + 1'b1;
      if (tick) begin
        cnt_value <= cnt_next;
        dir_down  <= dir_next;
      end
    end
  end

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator with double-buffered period/mode/duty settings.
//   clk, rst_n     : clock, asynchronous active-low reset
//   enable         : run control; low idles counter and outputs, loads apply at once
//   prescale       : counter advances every prescale+1 clk (not shadowed)
//   cfg            : configuration bus (shadow values + load_req/load_done)
//   period_strobe  : one-clk pulse the clk after each period boundary tick
//   cnt_value      : current counter value
//   pwm_out        : per-channel outputs, registered one clk after cnt_value
// Optional macro PWM_POLARITY_EN: per-channel output polarity, shadowed like
// duty; while disabled each output rests at its polarity (idle level).
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [PRESC_W-1:0]       prescale,
  pwm_multi_channel_if.slave       cfg,
  output logic                     period_strobe,
  output logic [CNT_W-1:0]         cnt_value,
  output logic [NUM_CH-1:0]        pwm_out
);

  logic [CNT_W-1:0]  period_act;
  logic              mode_act;
  logic              pending;
  logic              load_done_q;
  logic              tick;
  logic              at_end;
  logic              period_end;
  logic              do_load;
`ifdef PWM_POLARITY_EN
  logic [NUM_CH-1:0] pol_act;
`endif

  pwm_timebase #(
    .CNT_W   (CNT_W),
    .PRESC_W (PRESC_W)
  ) u_timebase (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .prescale   (prescale),
    .period_act (period_act),
    .mode_act   (mode_act),
    .cnt_value  (cnt_value),
    .tick       (tick),
    .boundary   (at_end)
  );

  assign period_end = tick & at_end;
  // A same-cycle load_req counts as pending; while idle there is no period
  // to protect, so the load goes through immediately.
  assign do_load    = (pending | cfg.load_req) & (period_end | ~enable);
  assign cfg.load_done = load_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_act    <= '0;
      mode_act      <= MODE_EDGE;
      pending       <= 1'b0;
      load_done_q   <= 1'b0;
      period_strobe <= 1'b0;
`ifdef PWM_POLARITY_EN
      pol_act       <= '0;
`endif
    end else begin
      load_done_q   <= do_load;
      period_strobe <= period_end;
      if (do_load) begin
        pending    <= 1'b0;
        period_act <= cfg.period;
        mode_act   <= cfg.center_mode;
`ifdef PWM_POLARITY_EN
        pol_act    <= cfg.polarity;
`endif
      end else if (cfg.load_req) begin
        pending <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] duty_act;
    logic             pwm_q;
    logic             cmp;

    assign cmp        = cnt_value < duty_act;
    assign pwm_out[i] = pwm_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        duty_act <= '0;
        pwm_q    <= 1'b0;
      end else begin
        if (do_load) duty_act <= CNT_W'(duty_of(DUTY_BUS_MAX'(cfg.duty), i, CNT_W));
`ifdef PWM_POLARITY_EN
        pwm_q <= enable ? (cmp ^ pol_act[i]) : pol_act[i];
`else
        pwm_q <= enable & cmp;
`endif
      end
    end
  end

endmodule
